// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between instruction
// fetch (IF) and data memory (DM). DM has priority over IF. Each access runs
// IDLE/DONE -> ACCESS (MEM_LAT cycles) -> DONE, and a request seen in DONE
// starts the next access back-to-back.
// Optional build macro: MEMARB_ANTI_STARVE_EN. When it is defined, a
// saturating counter forces IF ahead of DM after STARVE_MAX consecutive
// decisions that IF lost while it was requesting.
module mem_port_arbiter #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_valid,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_valid,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_sel,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // A single-cycle access still needs a one-bit counter.
  localparam int unsigned CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  // Reject parameter values that cannot describe a real memory or starve limit.
  if (MEM_LAT < 1 || STARVE_MAX < 1) begin : g_param_check
    $error("mem_port_arbiter: MEM_LAT and STARVE_MAX must both be >= 1");
  end

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          owner;      // 1 = DM owns the current access, 0 = IF
  logic          we_lat;     // write flag of the current access
  logic          decide;     // arbitration happens at this clock edge
  logic          dm_wins;    // winner of the arbitration, valid with decide
  logic          force_if;   // IF has been starved long enough to override DM
  logic          first_cyc;  // first cycle of ACCESS (grant / strobe cycle)

`ifdef MEMARB_ANTI_STARVE_EN
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve;

  assign force_if = if_req && (starve == SW'(STARVE_MAX));

  // Count decisions IF lost while requesting; any IF win clears the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve <= '0;
    end else if (decide) begin
      if (!dm_wins) begin
        starve <= '0;
      end else if (if_req && (starve != SW'(STARVE_MAX))) begin
        starve <= starve + 1'b1;
      end
    end
  end
`else
  assign force_if = 1'b0;
`endif

  // State register and access counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic: arbitration only in IDLE or DONE, ACCESS is a fixed countdown.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    decide    = 1'b0;
    dm_wins   = dm_req && !force_if;
    unique case (state)
      IDLE, DONE: begin
        if (if_req || dm_req) begin
          decide    = 1'b1;
          state_nxt = ACCESS;
          cnt_nxt   = CW'(MEM_LAT - 1);
        end else begin
          state_nxt = IDLE;
        end
      end
      ACCESS: begin
        if (cnt == '0) begin
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Latch the winner's request so the mux select and address stay stable
  // for the whole ACCESS/DONE period.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_sel   <= 1'b0;
      owner     <= 1'b0;
      we_lat    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (decide) begin
      mem_sel   <= dm_wins;
      owner     <= dm_wins;
      we_lat    <= dm_wins && dm_we;
      mem_addr  <= dm_wins ? dm_addr : if_addr;
      mem_wdata <= dm_wins ? dm_wdata : '0;
    end
  end

  // Grant/strobe pulses in the first ACCESS cycle, valid pulse and data
  // pass-through to the owner in DONE.
  always_comb begin
    first_cyc = (state == ACCESS) && (cnt == CW'(MEM_LAT - 1));
    mem_en    = first_cyc;
    mem_we    = first_cyc && we_lat;
    if_gnt    = first_cyc && !owner;
    dm_gnt    = first_cyc && owner;
    if_valid  = (state == DONE) && !owner;
    dm_valid  = (state == DONE) && owner;
    if_rdata  = if_valid ? mem_rdata : '0;
    dm_rdata  = dm_valid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed vector table, hand-written
// multi-cycle sequences, and randomized traffic against a transaction-level
// reference model. The second instance uses a single-cycle memory.
module tb_mem_port_arbiter;

  localparam int unsigned ML = 2;
  localparam int unsigned SM = 4;
`ifdef MEMARB_ANTI_STARVE_EN
  localparam bit ANTI = 1'b1;
`else
  localparam bit ANTI = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;

  logic        if_req, if_gnt, if_valid;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_gnt, dm_valid;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_sel, mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        if_req1, if_gnt1, if_valid1;
  logic [31:0] if_addr1, if_rdata1;
  logic        dm_req1, dm_we1, dm_gnt1, dm_valid1;
  logic [31:0] dm_addr1, dm_wdata1, dm_rdata1;
  logic        mem_sel1, mem_en1, mem_we1;
  logic [31:0] mem_addr1, mem_wdata1, mem_rdata1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(ML), .STARVE_MAX(SM)) u0 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_valid(dm_valid), .dm_rdata(dm_rdata),
    .mem_sel(mem_sel), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .STARVE_MAX(SM)) u1 (
    .clk(clk), .rst(rst),
    .if_req(if_req1), .if_addr(if_addr1), .if_gnt(if_gnt1), .if_valid(if_valid1), .if_rdata(if_rdata1),
    .dm_req(dm_req1), .dm_we(dm_we1), .dm_addr(dm_addr1), .dm_wdata(dm_wdata1),
    .dm_gnt(dm_gnt1), .dm_valid(dm_valid1), .dm_rdata(dm_rdata1),
    .mem_sel(mem_sel1), .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
  );

  // Power-on memory contents shared by the environment and the reference model.
  function automatic logic [31:0] init_val(int unsigned i);
    logic [7:0] b;
    b = 8'(i);
    if (i == 16) return 32'hAAAA_AAAA;
    if (i == 64) return 32'h1234_5678;
    return {b, ~b, 16'hC0DE};
  endfunction

  // Fixed-latency memory model for u0: data appears exactly ML cycles after mem_en.
  logic [31:0] memarr [256];
  logic        mem_ready = 1'b0;
  logic        rd_v [ML];
  logic [31:0] rd_d [ML];

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) memarr[i] <= init_val(i);
      mem_ready <= 1'b1;
    end else if (mem_en && mem_we) begin
      memarr[mem_addr[9:2]] <= mem_wdata;
    end
    rd_v[0] <= mem_en && !mem_we;
    rd_d[0] <= memarr[mem_addr[9:2]];
    for (int i = 1; i < ML; i++) begin
      rd_v[i] <= rd_v[i-1];
      rd_d[i] <= rd_d[i-1];
    end
  end
  assign mem_rdata = rd_v[ML-1] ? rd_d[ML-1] : 32'hDEAD_BEEF;

  // Single-cycle read-only memory model for u1.
  always @(posedge clk) begin
    mem_rdata1 <= (mem_en1 && !mem_we1) ? init_val(32'(mem_addr1[9:2])) : 32'hDEAD_BEEF;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    if_req1 = 1'b0; if_addr1 = '0; dm_req1 = 1'b0; dm_we1 = 1'b0; dm_addr1 = '0; dm_wdata1 = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic        rst, ifr;
    logic [31:0] ifa;
    logic        dmr, dwe;
    logic [31:0] dma, dwd;
    logic [6:0]  flg;   // {if_gnt, if_valid, dm_gnt, dm_valid, mem_sel, mem_en, mem_we}
    logic [31:0] ird, drd;
    logic        cdrd;
    logic [31:0] addr, wd;
    logic        cwd;
  } vec_t;

  function automatic vec_t mk(logic r, logic ifr, logic [31:0] ifa, logic dmr, logic dwe,
                              logic [31:0] dma, logic [31:0] dwd, logic [6:0] flg,
                              logic [31:0] ird, logic [31:0] drd, logic cdrd,
                              logic [31:0] addr, logic [31:0] wd, logic cwd);
    vec_t v;
    v.rst = r; v.ifr = ifr; v.ifa = ifa; v.dmr = dmr; v.dwe = dwe; v.dma = dma; v.dwd = dwd;
    v.flg = flg; v.ird = ird; v.drd = drd; v.cdrd = cdrd; v.addr = addr; v.wd = wd; v.cwd = cwd;
    return v;
  endfunction

  vec_t        tbl [20];
  logic [31:0] ref_mem [256];
  int          next_dec, gnt_c, done_c, starve, ng, last;
  logic        own_dm, acc_we, sel_e, fif, dmw, exp_if;
  logic [31:0] acc_addr, acc_wd, acc_rd;

  initial begin
    // Row inputs are applied, one clock passes, then the row's outputs are checked.
    tbl[0]  = mk(1, 1, 32'h40, 1, 0, 32'h100, 0,            7'b0000000, 0, 0, 1, 0, 0, 1);
    tbl[1]  = mk(1, 1, 32'h40, 1, 0, 32'h100, 0,            7'b0000000, 0, 0, 1, 0, 0, 1);
    tbl[2]  = mk(0, 0, 0,      1, 0, 32'h100, 0,            7'b0010110, 0, 0, 1, 32'h100, 0, 1);
    tbl[3]  = mk(0, 0, 0,      0, 0, 0,       0,            7'b0000100, 0, 0, 1, 32'h100, 0, 1);
    tbl[4]  = mk(0, 0, 0,      0, 0, 0,       0,            7'b0001100, 0, 32'h1234_5678, 1, 32'h100, 0, 1);
    tbl[5]  = mk(0, 0, 0,      0, 0, 0,       0,            7'b0000100, 0, 0, 1, 32'h100, 0, 1);
    tbl[6]  = mk(0, 1, 32'h40, 0, 0, 0,       0,            7'b1000010, 0, 0, 1, 32'h40, 0, 0);
    tbl[7]  = mk(0, 0, 0,      0, 0, 0,       0,            7'b0000000, 0, 0, 1, 32'h40, 0, 0);
    tbl[8]  = mk(0, 0, 0,      0, 0, 0,       0,            7'b0100000, 32'hAAAA_AAAA, 0, 1, 32'h40, 0, 0);
    tbl[9]  = mk(0, 1, 32'h80, 1, 1, 32'h100, 32'h5555_5555, 7'b0010111, 0, 0, 1, 32'h100, 32'h5555_5555, 1);
    tbl[10] = mk(0, 1, 32'h80, 0, 0, 0,       0,            7'b0000100, 0, 0, 1, 32'h100, 32'h5555_5555, 1);
    tbl[11] = mk(0, 1, 32'h80, 0, 0, 0,       0,            7'b0001100, 0, 0, 0, 32'h100, 32'h5555_5555, 1);
    tbl[12] = mk(0, 1, 32'h80, 0, 0, 0,       0,            7'b1000010, 0, 0, 1, 32'h80, 0, 0);
    tbl[13] = mk(0, 0, 0,      0, 0, 0,       0,            7'b0000000, 0, 0, 1, 32'h80, 0, 0);
    tbl[14] = mk(0, 0, 0,      0, 0, 0,       0,            7'b0100000, init_val(32), 0, 1, 32'h80, 0, 0);
    tbl[15] = mk(0, 0, 0,      0, 0, 0,       0,            7'b0000000, 0, 0, 1, 32'h80, 0, 0);
    tbl[16] = mk(0, 0, 0,      1, 0, 32'h200, 0,            7'b0010110, 0, 0, 1, 32'h200, 0, 1);
    tbl[17] = mk(0, 0, 0,      0, 0, 0,       0,            7'b0000100, 0, 0, 1, 32'h200, 0, 1);
    tbl[18] = mk(1, 0, 0,      0, 0, 0,       0,            7'b0000000, 0, 0, 1, 0, 0, 1);
    tbl[19] = mk(0, 0, 0,      0, 0, 0,       0,            7'b0000000, 0, 0, 1, 0, 0, 1);

    if_req1 = 1'b0; if_addr1 = '0; dm_req1 = 1'b0; dm_we1 = 1'b0; dm_addr1 = '0; dm_wdata1 = '0;

    // Directed vectors: reset, single IF read, DM write beating IF, reset mid-access.
    for (int i = 0; i < 20; i++) begin
      rst = tbl[i].rst; if_req = tbl[i].ifr; if_addr = tbl[i].ifa;
      dm_req = tbl[i].dmr; dm_we = tbl[i].dwe; dm_addr = tbl[i].dma; dm_wdata = tbl[i].dwd;
      @(negedge clk);
      chk($sformatf("r%0d flags", i),
          32'({if_gnt, if_valid, dm_gnt, dm_valid, mem_sel, mem_en, mem_we}), 32'(tbl[i].flg));
      chk($sformatf("r%0d if_rdata", i), if_rdata, tbl[i].ird);
      if (tbl[i].cdrd) chk($sformatf("r%0d dm_rdata", i), dm_rdata, tbl[i].drd);
      chk($sformatf("r%0d mem_addr", i), mem_addr, tbl[i].addr);
      if (tbl[i].cwd) chk($sformatf("r%0d mem_wdata", i), mem_wdata, tbl[i].wd);
    end

    // Both requesters held high: grant order shows the priority / anti-starve rule.
    do_reset();
    if_req = 1'b1; if_addr = 32'h4; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0;
    ng = 0; last = -1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (if_gnt || dm_gnt) begin
        exp_if = ANTI && ((ng % 5) == 4);
        chk($sformatf("hold grant%0d if_gnt", ng), 32'(if_gnt), 32'(exp_if));
        chk($sformatf("hold grant%0d dm_gnt", ng), 32'(dm_gnt), 32'(!exp_if));
        chk($sformatf("hold grant%0d spacing", ng), 32'(k - last), (ng == 0) ? 32'(1) : 32'(ML + 1));
        last = k;
        ng++;
      end
    end
    chk("hold grant count", 32'(ng), 32'd10);

    // Single-cycle memory: IF reads back-to-back, grant every 2 cycles.
    do_reset();
    if_req1 = 1'b1; if_addr1 = 32'(10 << 2);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk($sformatf("lat1 c%0d if_gnt", k), 32'(if_gnt1), 32'((k % 2) == 0));
      chk($sformatf("lat1 c%0d if_valid", k), 32'(if_valid1), 32'((k % 2) == 1));
      chk($sformatf("lat1 c%0d if_rdata", k), if_rdata1,
          ((k % 2) == 1) ? init_val(10 + k / 2) : 32'h0);
      chk($sformatf("lat1 c%0d mem_addr", k), mem_addr1, 32'((10 + k / 2) << 2));
      chk($sformatf("lat1 c%0d dm side", k),
          {27'b0, dm_gnt1, dm_valid1, mem_sel1, mem_we1, |mem_wdata1} | dm_rdata1, 32'h0);
      if ((k % 2) == 1) if_addr1 = 32'((10 + k / 2 + 1) << 2);
    end
    if_req1 = 1'b0;

    // Randomized traffic against a transaction-timeline reference model.
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    ref_mem[64] = 32'h5555_5555;
    do_reset();
    next_dec = 0; gnt_c = -10; done_c = -10; starve = 0;
    own_dm = 1'b0; acc_we = 1'b0; sel_e = 1'b0; acc_addr = '0; acc_wd = '0; acc_rd = '0;
    for (int k = 0; k < 600; k++) begin
      chk($sformatf("rnd%0d if_gnt", k), 32'(if_gnt), 32'(k == gnt_c && !own_dm));
      chk($sformatf("rnd%0d dm_gnt", k), 32'(dm_gnt), 32'(k == gnt_c && own_dm));
      chk($sformatf("rnd%0d if_valid", k), 32'(if_valid), 32'(k == done_c && !own_dm));
      chk($sformatf("rnd%0d dm_valid", k), 32'(dm_valid), 32'(k == done_c && own_dm));
      chk($sformatf("rnd%0d mem_en/we", k), 32'({mem_en, mem_we}),
          32'({k == gnt_c, k == gnt_c && acc_we}));
      chk($sformatf("rnd%0d mem_sel", k), 32'(mem_sel), 32'(sel_e));
      chk($sformatf("rnd%0d mem_addr", k), mem_addr, acc_addr);
      if (k == gnt_c && acc_we) chk($sformatf("rnd%0d mem_wdata", k), mem_wdata, acc_wd);
      if (k == done_c) begin
        if (!own_dm) begin
          chk($sformatf("rnd%0d if_rdata", k), if_rdata, acc_rd);
          chk($sformatf("rnd%0d dm_rdata idle", k), dm_rdata, 32'h0);
        end else begin
          chk($sformatf("rnd%0d if_rdata idle", k), if_rdata, 32'h0);
          if (!acc_we) chk($sformatf("rnd%0d dm_rdata", k), dm_rdata, acc_rd);
        end
      end

      // Requesters hold req until granted, then may drop or issue another access.
      if (if_req && k == gnt_c && !own_dm) begin
        if ($urandom_range(1, 0) == 1) if_addr = 32'($urandom_range(127, 0) << 2);
        else if_req = 1'b0;
      end else if (!if_req && $urandom_range(99, 0) < 40) begin
        if_req = 1'b1; if_addr = 32'($urandom_range(127, 0) << 2);
      end
      if (dm_req && k == gnt_c && own_dm) begin
        if ($urandom_range(1, 0) == 1) begin
          dm_addr = 32'($urandom_range(127, 0) << 2); dm_we = 1'($urandom_range(1, 0)); dm_wdata = $urandom;
        end else dm_req = 1'b0;
      end else if (!dm_req && $urandom_range(99, 0) < 40) begin
        dm_req = 1'b1; dm_addr = 32'($urandom_range(127, 0) << 2);
        dm_we = 1'($urandom_range(1, 0)); dm_wdata = $urandom;
      end

      // Arbitration when the port is free: DM first unless IF has hit the starve limit.
      if (k >= next_dec && (if_req || dm_req)) begin
        fif = ANTI && if_req && (starve == SM);
        dmw = dm_req && !fif;
        if (ANTI) begin
          if (!dmw) starve = 0;
          else if (if_req && starve < SM) starve++;
        end
        own_dm = dmw; sel_e = dmw;
        acc_addr = dmw ? dm_addr : if_addr;
        acc_we = dmw && dm_we;
        acc_wd = dm_wdata;
        if (acc_we) ref_mem[acc_addr[9:2]] = dm_wdata;
        acc_rd = ref_mem[acc_addr[9:2]];
        gnt_c = k + 1;
        done_c = k + 1 + ML;
        next_dec = done_c;
      end
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
